sigdump_ctrl: RTL and testbench

- Compliance-signature dump controller on the mmRISC-1 AHB-Lite data bus.
- Provides a TOHOST register that CPU software writes to signal test end.
- On a TOHOST write of 1, it becomes an AHB-Lite master and reads the word range [DUMP_BGN, DUMP_END) from RAM.
- It streams each word out over a valid/ready port to a UART or host sink, then raises DONE.
- Replaces the backdoor memory peek so signature extraction also works on FPGA.

---
 rtl/sigdump_pkg.sv | 28 ++
 rtl/sigdump_if.sv | 43 ++++
 rtl/sigdump_ahbm_rd.sv | 69 ++++++
 rtl/sigdump_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sigdump_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sigdump_pkg.sv
// Shared constants, state encodings and helpers for the compliance-signature dump controller.
package sigdump_pkg;

  localparam logic [2:0] SIGDUMP_OFS_TOHOST = 3'd0;
  localparam logic [2:0] SIGDUMP_OFS_BGN    = 3'd1;
  localparam logic [2:0] SIGDUMP_OFS_END    = 3'd2;
  localparam logic [2:0] SIGDUMP_OFS_STAT   = 3'd3;
  localparam logic [2:0] SIGDUMP_OFS_CHK    = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {CS_IDLE, CS_READ, CS_PUSH, CS_FIN} ctrl_state_e;
  typedef enum logic [1:0] {RS_IDLE, RS_ADDR, RS_DATA} rd_state_e;

  // Number of words in [bgn, fin), zero for an empty or inverted range, capped at max_w.
  function automatic logic [31:0] word_count(input logic [31:0] bgn, input logic [31:0] fin,
                                             input logic [31:0] max_w);
    logic [31:0] n;
    if (fin > bgn) n = (fin - bgn) >> 2;
    else           n = 32'd0;
    if (n > max_w) n = max_w;
    else           n = n;
    return n;
  endfunction

endpackage

// File: rtl/sigdump_if.sv
// Bus bundle for sigdump_ctrl: AHB-Lite slave, AHB-Lite read master, signature stream and DONE.
interface sigdump_if;
  logic        S_HSEL;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE;
  logic [2:0]  S_HSIZE;
  logic [31:0] S_HADDR;
  logic [31:0] S_HWDATA;
  logic        S_HREADY;
  logic        S_HREADYOUT;
  logic        S_HRESP;
  logic [31:0] S_HRDATA;
  logic [1:0]  M_HTRANS;
  logic [31:0] M_HADDR;
  logic [2:0]  M_HSIZE;
  logic        M_HWRITE;
  logic [31:0] M_HRDATA;
  logic        M_HREADY;
  logic        M_HRESP;
  logic        SIG_VALID;
  logic [31:0] SIG_DATA;
  logic        SIG_LAST;
  logic        SIG_READY;
  logic        DONE;

  modport slave (
    input  S_HSEL, S_HTRANS, S_HWRITE, S_HSIZE, S_HADDR, S_HWDATA, S_HREADY,
    output S_HREADYOUT, S_HRESP, S_HRDATA,
    output M_HTRANS, M_HADDR, M_HSIZE, M_HWRITE,
    input  M_HRDATA, M_HREADY, M_HRESP,
    output SIG_VALID, SIG_DATA, SIG_LAST, DONE,
    input  SIG_READY
  );

  modport master (
    output S_HSEL, S_HTRANS, S_HWRITE, S_HSIZE, S_HADDR, S_HWDATA, S_HREADY,
    input  S_HREADYOUT, S_HRESP, S_HRDATA,
    input  M_HTRANS, M_HADDR, M_HSIZE, M_HWRITE,
    output M_HRDATA, M_HREADY, M_HRESP,
    input  SIG_VALID, SIG_DATA, SIG_LAST, DONE,
    output SIG_READY
  );
endinterface

// File: rtl/sigdump_ahbm_rd.sv
// Single-word AHB-Lite read engine: a req pulse in idle launches one NONSEQ read, ack pulses
// when the data phase completes, with rdata/err valid in that cycle.
module sigdump_ahbm_rd
  import sigdump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  m_htrans,
  output logic [31:0] m_haddr,
  input  logic [31:0] m_hrdata,
  input  logic        m_hready,
  input  logic        m_hresp
);

  rd_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;

  // Next state: address phase holds until HREADY, data phase completes on HREADY.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ack     = 1'b0;
    case (state_q)
      RS_IDLE: begin
        if (req) begin
          state_d = RS_ADDR;
          addr_d  = addr;
        end else begin
          state_d = RS_IDLE;
        end
      end
      RS_ADDR: begin
        if (m_hready) state_d = RS_DATA;
        else          state_d = RS_ADDR;
      end
      RS_DATA: begin
        if (m_hready) begin
          ack     = 1'b1;
          state_d = RS_IDLE;
        end else begin
          state_d = RS_DATA;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  // State and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RS_IDLE;
      addr_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign m_htrans = (state_q == RS_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign m_haddr  = addr_q;
  assign rdata    = m_hrdata;
  assign err      = m_hresp;

endmodule

// File: rtl/sigdump_ctrl.sv
// Compliance-signature dump controller: TOHOST write of 1 reads [DUMP_BGN, DUMP_END) over AHB-Lite
// and streams the words out. Define SIGDUMP_CHKSUM_EN to add the running checksum at offset 0x10.
module sigdump_ctrl
  import sigdump_pkg::*;
#(
  parameter logic [31:0] BGN_RST   = 32'h0000_0000,
  parameter logic [31:0] END_RST   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 65536
) (
  input  logic     CLK,
  input  logic     RES_N,
  sigdump_if.slave bus
);

  ctrl_state_e state_q, state_d;
  logic        s_wr_q, s_wr_d, s_rd_q, s_rd_d;
  logic [2:0]  s_ofs_q, s_ofs_d;
  logic [31:0] tohost_q, tohost_d, bgn_q, bgn_d, end_q, end_d;
  logic [31:0] n_q, n_d, ptr_q, ptr_d, cnt_q, cnt_d;
  logic        done_q, done_d, err_q, err_d;
  logic        sig_valid_q, sig_valid_d, sig_last_q, sig_last_d;
  logic [31:0] sig_data_q, sig_data_d;
  logic        addr_ph_s, busy_s, start_s, hs_s;
  logic        rd_req_s, rd_ack_s, rd_err_s;
  logic [31:0] rd_addr_s, rd_data_s, chk_s, hrdata_s;
  logic        unused_addr_s;

  assign addr_ph_s = bus.S_HSEL && bus.S_HTRANS[1] && bus.S_HREADY;
  assign s_wr_d    = addr_ph_s && bus.S_HWRITE && (bus.S_HSIZE == HSIZE_WORD);
  assign s_rd_d    = addr_ph_s && !bus.S_HWRITE;
  assign s_ofs_d   = addr_ph_s ? bus.S_HADDR[4:2] : s_ofs_q;
  assign busy_s    = (state_q == CS_READ) || (state_q == CS_PUSH);
  assign start_s   = s_wr_q && (s_ofs_q == SIGDUMP_OFS_TOHOST) && (bus.S_HWDATA == 32'h0000_0001) && !busy_s;
  assign hs_s      = sig_valid_q && bus.SIG_READY;

  sigdump_ahbm_rd u_rd (
    .clk      (CLK),
    .rst_n    (RES_N),
    .req      (rd_req_s),
    .addr     (rd_addr_s),
    .ack      (rd_ack_s),
    .rdata    (rd_data_s),
    .err      (rd_err_s),
    .m_htrans (bus.M_HTRANS),
    .m_haddr  (bus.M_HADDR),
    .m_hrdata (bus.M_HRDATA),
    .m_hready (bus.M_HREADY),
    .m_hresp  (bus.M_HRESP)
  );

  // Register writes and dump sequencing; the read engine is kicked in the same cycle we leave IDLE/PUSH.
  always_comb begin
    state_d     = state_q;
    tohost_d    = tohost_q;
    bgn_d       = bgn_q;
    end_d       = end_q;
    n_d         = n_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    err_d       = err_q;
    sig_valid_d = sig_valid_q;
    sig_last_d  = sig_last_q;
    sig_data_d  = sig_data_q;
    rd_req_s    = 1'b0;
    rd_addr_s   = ptr_q;
    if (s_wr_q) begin
      case (s_ofs_q)
        SIGDUMP_OFS_TOHOST: tohost_d = bus.S_HWDATA;
        SIGDUMP_OFS_BGN:    if (!busy_s) bgn_d = {bus.S_HWDATA[31:2], 2'b00}; else bgn_d = bgn_q;
        SIGDUMP_OFS_END:    if (!busy_s) end_d = {bus.S_HWDATA[31:2], 2'b00}; else end_d = end_q;
        default:            tohost_d = tohost_q;
      endcase
    end else begin
      tohost_d = tohost_q;
    end
    case (state_q)
      CS_IDLE, CS_FIN: begin
        if (start_s) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          cnt_d  = 32'd0;
          n_d    = word_count(bgn_q, end_q, 32'(MAX_WORDS));
          if (n_d == 32'd0) begin
            done_d  = 1'b1;
            state_d = CS_FIN;
          end else begin
            ptr_d     = bgn_q;
            rd_req_s  = 1'b1;
            rd_addr_s = bgn_q;
            state_d   = CS_READ;
          end
        end else begin
          state_d = CS_IDLE;
        end
      end
      CS_READ: begin
        if (rd_ack_s && rd_err_s) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = CS_FIN;
        end else if (rd_ack_s) begin
          sig_data_d  = rd_data_s;
          sig_valid_d = 1'b1;
          sig_last_d  = (cnt_q + 32'd1 == n_q);
          state_d     = CS_PUSH;
        end else begin
          state_d = CS_READ;
        end
      end
      CS_PUSH: begin
        if (hs_s) begin
          sig_valid_d = 1'b0;
          sig_last_d  = 1'b0;
          cnt_d       = cnt_q + 32'd1;
          ptr_d       = ptr_q + 32'd4;
          if (sig_last_q) begin
            done_d  = 1'b1;
            state_d = CS_FIN;
          end else begin
            rd_req_s  = 1'b1;
            rd_addr_s = ptr_q + 32'd4;
            state_d   = CS_READ;
          end
        end else begin
          state_d = CS_PUSH;
        end
      end
      default: state_d = CS_IDLE;
    endcase
  end

  // All controller state; reset aborts any dump in flight.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q     <= CS_IDLE;
      s_wr_q      <= 1'b0;
      s_rd_q      <= 1'b0;
      s_ofs_q     <= 3'd0;
      tohost_q    <= 32'h0000_0000;
      bgn_q       <= BGN_RST;
      end_q       <= END_RST;
      n_q         <= 32'd0;
      ptr_q       <= 32'h0000_0000;
      cnt_q       <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sig_valid_q <= 1'b0;
      sig_last_q  <= 1'b0;
      sig_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      s_wr_q      <= s_wr_d;
      s_rd_q      <= s_rd_d;
      s_ofs_q     <= s_ofs_d;
      tohost_q    <= tohost_d;
      bgn_q       <= bgn_d;
      end_q       <= end_d;
      n_q         <= n_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sig_valid_q <= sig_valid_d;
      sig_last_q  <= sig_last_d;
      sig_data_q  <= sig_data_d;
    end
  end

`ifdef SIGDUMP_CHKSUM_EN
  logic [31:0] chk_q, chk_d;

  // Running sum of accepted stream words, restarted with each dump.
  always_comb begin
    if (start_s)   chk_d = 32'd0;
    else if (hs_s) chk_d = chk_q + sig_data_q;
    else           chk_d = chk_q;
  end

  // Checksum register.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) chk_q <= 32'd0;
    else        chk_q <= chk_d;
  end

  assign chk_s = chk_q;
`else
  assign chk_s = 32'd0;
`endif

  // Read mux driven from the captured address phase; only meaningful in a read data phase.
  always_comb begin
    hrdata_s = 32'h0000_0000;
    if (s_rd_q) begin
      case (s_ofs_q)
        SIGDUMP_OFS_TOHOST: hrdata_s = tohost_q;
        SIGDUMP_OFS_BGN:    hrdata_s = bgn_q;
        SIGDUMP_OFS_END:    hrdata_s = end_q;
        SIGDUMP_OFS_STAT:   hrdata_s = {cnt_q[15:0], 13'd0, err_q, done_q, busy_s};
        SIGDUMP_OFS_CHK:    hrdata_s = chk_s;
        default:            hrdata_s = 32'h0000_0000;
      endcase
    end else begin
      hrdata_s = 32'h0000_0000;
    end
  end

  assign bus.S_HRDATA    = hrdata_s;
  assign bus.S_HREADYOUT = 1'b1;
  assign bus.S_HRESP     = 1'b0;
  assign bus.M_HSIZE     = HSIZE_WORD;
  assign bus.M_HWRITE    = 1'b0;
  assign bus.SIG_VALID   = sig_valid_q;
  assign bus.SIG_DATA    = sig_data_q;
  assign bus.SIG_LAST    = sig_last_q;
  assign bus.DONE        = done_q;
  assign unused_addr_s   = ^{bus.S_HADDR[31:5], bus.S_HADDR[1:0]};

endmodule

// File: tb/tb_sigdump_ctrl.sv
// Directed self-checking bench for sigdump_ctrl with a small AHB-Lite RAM model and stream sink.
module tb_sigdump_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sigdump_if bus ();

  sigdump_ctrl #(.BGN_RST(32'h0000_0300), .END_RST(32'h0000_030C), .MAX_WORDS(65536)) dut (
    .CLK   (clk),
    .RES_N (rst_n),
    .bus   (bus)
  );

`ifdef SIGDUMP_CHKSUM_EN
  localparam logic [31:0] CHK_EXP = 32'h0000_00AA;
`else
  localparam logic [31:0] CHK_EXP = 32'h0000_0000;
`endif

  int checks = 0;
  int passes = 0;

  // RAM model and fault/stall injection
  logic        sig_ready = 1'b0;
  logic        stall_en = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          stall_cnt = 0;
  logic        stall_act;
  logic        dp_q = 1'b0;
  logic [31:0] dp_addr = 32'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign stall_act    = stall_en && (bus.M_HTRANS == 2'b10) && (bus.M_HADDR == 32'h104) && (stall_cnt < 3);
  assign bus.M_HREADY = !stall_act;
  assign bus.M_HRDATA = dp_q ? mem_rd(dp_addr) : 32'h0;
  assign bus.M_HRESP  = dp_q && err_en && (dp_addr == err_addr);
  assign bus.SIG_READY = sig_ready;
  assign bus.S_HREADY = 1'b1;

  always @(posedge clk) begin
    if (!stall_en) stall_cnt <= 0;
    else if (stall_act) stall_cnt <= stall_cnt + 1;
    if (bus.M_HREADY) begin
      dp_q    <= (bus.M_HTRANS == 2'b10);
      dp_addr <= bus.M_HADDR;
    end
  end

  // Stream and bus monitor
  logic [31:0] cap_data[$];
  logic        cap_last[$];
  int stab_err = 0, htrans_seen = 0, valid_seen = 0, stall_seen = 0, stall_ok = 0;
  logic prev_hold = 1'b0;
  logic [31:0] prev_data = 32'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.SIG_VALID && bus.SIG_READY) begin
        cap_data.push_back(bus.SIG_DATA);
        cap_last.push_back(bus.SIG_LAST);
      end
      if (prev_hold && (!bus.SIG_VALID || bus.SIG_DATA != prev_data)) stab_err++;
      prev_hold = bus.SIG_VALID && !bus.SIG_READY;
      prev_data = bus.SIG_DATA;
      if (bus.M_HTRANS != 2'b00) htrans_seen++;
      if (bus.SIG_VALID) valid_seen++;
      if (!bus.M_HREADY) begin
        stall_seen++;
        if (bus.M_HADDR == 32'h104 && bus.M_HTRANS == 2'b10) stall_ok++;
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    @(negedge clk);
    bus.S_HSEL = 1'b1; bus.S_HTRANS = 2'b10; bus.S_HWRITE = 1'b1; bus.S_HSIZE = size; bus.S_HADDR = addr;
    @(negedge clk);
    bus.S_HSEL = 1'b0; bus.S_HTRANS = 2'b00; bus.S_HWRITE = 1'b0; bus.S_HWDATA = data;
    @(negedge clk);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.S_HSEL = 1'b1; bus.S_HTRANS = 2'b10; bus.S_HWRITE = 1'b0; bus.S_HSIZE = 3'b010; bus.S_HADDR = addr;
    @(negedge clk);
    bus.S_HSEL = 1'b0; bus.S_HTRANS = 2'b00;
    data = bus.S_HRDATA;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!bus.DONE && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    checks++; if (bus.S_HREADYOUT !== 1'b1) $display("FAIL rst_hreadyout: got %b want 1", bus.S_HREADYOUT); else passes++;
    checks++; if (bus.S_HRESP !== 1'b0) $display("FAIL rst_hresp: got %b want 0", bus.S_HRESP); else passes++;
    checks++; if (bus.M_HSIZE !== 3'b010) $display("FAIL rst_mhsize: got %b want 010", bus.M_HSIZE); else passes++;
    checks++; if (bus.M_HTRANS !== 2'b00 || bus.M_HADDR !== 32'h0 || bus.M_HWRITE !== 1'b0)
      $display("FAIL rst_master: got htrans=%b haddr=%h hwrite=%b want 00/0/0", bus.M_HTRANS, bus.M_HADDR, bus.M_HWRITE); else passes++;
    checks++; if (bus.SIG_VALID !== 1'b0 || bus.SIG_LAST !== 1'b0 || bus.SIG_DATA !== 32'h0 || bus.DONE !== 1'b0)
      $display("FAIL rst_stream: got v=%b l=%b d=%h done=%b want all 0", bus.SIG_VALID, bus.SIG_LAST, bus.SIG_DATA, bus.DONE); else passes++;
    ahb_read(32'h04, rd);
    checks++; if (rd !== 32'h300) $display("FAIL rst_bgn: got %h want 00000300", rd); else passes++;
    ahb_read(32'h08, rd);
    checks++; if (rd !== 32'h30C) $display("FAIL rst_end: got %h want 0000030c", rd); else passes++;
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0) $display("FAIL rst_status: got %h want 00000000", rd); else passes++;
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    ahb_write(32'h04, 32'h0000_0555, 3'b000);
    ahb_read(32'h04, rd);
    checks++; if (rd !== 32'h300) $display("FAIL regs_bytewrite_ignored: got %h want 00000300", rd); else passes++;
    ahb_write(32'h04, 32'h0000_0123, 3'b010);
    ahb_read(32'h04, rd);
    checks++; if (rd !== 32'h120) $display("FAIL regs_bgn_lowbits: got %h want 00000120", rd); else passes++;
    ahb_read(32'h14, rd);
    checks++; if (rd !== 32'h0) $display("FAIL regs_undef: got %h want 00000000", rd); else passes++;
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic [3:0] lasts;
    int n0, cyc;
    ahb_write(32'h04, 32'h100, 3'b010);
    ahb_write(32'h08, 32'h110, 3'b010);
    sig_ready = 1'b1;
    n0 = cap_data.size();
    ahb_write(32'h00, 32'h1, 3'b010);
    wait_done(200, cyc);
    checks++; if (bus.DONE !== 1'b1) $display("FAIL basic_done: got %b want 1", bus.DONE); else passes++;
    checks++; if (cyc !== 12) $display("FAIL basic_latency: got %0d cycles want 12", cyc); else passes++;
    checks++; if (cap_data.size() - n0 !== 4) $display("FAIL basic_count: got %0d words want 4", cap_data.size() - n0); else passes++;
    if (cap_data.size() - n0 == 4) begin
      checks++; if (cap_data[n0] !== 32'h11 || cap_data[n0+1] !== 32'h22 || cap_data[n0+2] !== 32'h33 || cap_data[n0+3] !== 32'h44)
        $display("FAIL basic_data: got %h %h %h %h want 11 22 33 44", cap_data[n0], cap_data[n0+1], cap_data[n0+2], cap_data[n0+3]); else passes++;
      lasts = {cap_last[n0+3], cap_last[n0+2], cap_last[n0+1], cap_last[n0]};
      checks++; if (lasts !== 4'b1000) $display("FAIL basic_last: got %b want 1000", lasts); else passes++;
    end
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0004_0002) $display("FAIL basic_status: got %h want 00040002", rd); else passes++;
    ahb_read(32'h00, rd);
    checks++; if (rd !== 32'h1) $display("FAIL basic_tohost: got %h want 00000001", rd); else passes++;
    ahb_read(32'h10, rd);
    checks++; if (rd !== CHK_EXP) $display("FAIL basic_chksum: got %h want %h", rd, CHK_EXP); else passes++;
  endtask

  task automatic test_stall();
    int n0, s0, k0, cyc;
    stall_en = 1'b1;
    n0 = cap_data.size(); s0 = stall_seen; k0 = stall_ok;
    ahb_write(32'h00, 32'h1, 3'b010);
    wait_done(200, cyc);
    stall_en = 1'b0;
    checks++; if (cyc !== 15) $display("FAIL stall_latency: got %0d cycles want 15", cyc); else passes++;
    checks++; if (stall_seen - s0 !== 3 || stall_ok - k0 !== 3)
      $display("FAIL stall_addr_held: got %0d stall cycles, %0d at 104 NONSEQ want 3/3", stall_seen - s0, stall_ok - k0); else passes++;
    checks++; if (cap_data.size() - n0 !== 4 || cap_data[cap_data.size()-3] !== 32'h22 || cap_data[cap_data.size()-1] !== 32'h44)
      $display("FAIL stall_data: got %0d words want 4 ending 22 33 44", cap_data.size() - n0); else passes++;
  endtask

  task automatic test_back_to_back_bp();
    int n0, e0, cyc;
    sig_ready = 1'b0;
    n0 = cap_data.size(); e0 = stab_err;
    ahb_write(32'h00, 32'h1, 3'b010);
    cyc = 0;
    while (!bus.DONE && cyc < 300) begin
      @(posedge clk);
      #1 sig_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    sig_ready = 1'b1;
    checks++; if (bus.DONE !== 1'b1) $display("FAIL bp_done: got %b want 1", bus.DONE); else passes++;
    checks++; if (stab_err - e0 !== 0) $display("FAIL bp_stable: got %0d unstable holds want 0", stab_err - e0); else passes++;
    checks++; if (cap_data.size() - n0 !== 4 || cap_data[n0] !== 32'h11 || cap_data[n0+1] !== 32'h22 ||
                  cap_data[n0+2] !== 32'h33 || cap_data[n0+3] !== 32'h44)
      $display("FAIL bp_words: got %0d words want 4 = 11 22 33 44", cap_data.size() - n0); else passes++;
  endtask

  task automatic test_error();
    logic [31:0] rd;
    int n0, cyc;
    err_en = 1'b1; err_addr = 32'h108;
    n0 = cap_data.size();
    ahb_write(32'h00, 32'h1, 3'b010);
    wait_done(200, cyc);
    err_en = 1'b0;
    checks++; if (bus.DONE !== 1'b1) $display("FAIL err_done: got %b want 1", bus.DONE); else passes++;
    checks++; if (cap_data.size() - n0 !== 2 || cap_data[n0] !== 32'h11 || cap_data[n0+1] !== 32'h22 || cap_last[n0+1] !== 1'b0)
      $display("FAIL err_words: got %0d words want 2 = 11 22 without last", cap_data.size() - n0); else passes++;
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0002_0006) $display("FAIL err_status: got %h want 00020006", rd); else passes++;
  endtask

  task automatic test_empty();
    logic [31:0] rd;
    int h0, v0, cyc;
    ahb_write(32'h04, 32'h200, 3'b010);
    ahb_write(32'h08, 32'h200, 3'b010);
    h0 = htrans_seen; v0 = valid_seen;
    ahb_write(32'h00, 32'h1, 3'b010);
    wait_done(2, cyc);
    repeat (4) @(negedge clk);
    checks++; if (bus.DONE !== 1'b1 || cyc > 2) $display("FAIL empty_done: got done=%b after %0d cycles want 1 within 2", bus.DONE, cyc); else passes++;
    checks++; if (htrans_seen - h0 !== 0 || valid_seen - v0 !== 0)
      $display("FAIL empty_quiet: got %0d busy htrans, %0d valid cycles want 0/0", htrans_seen - h0, valid_seen - v0); else passes++;
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0000_0002) $display("FAIL empty_status: got %h want 00000002", rd); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n0, v0, cyc;
    ahb_write(32'h04, 32'h100, 3'b010);
    ahb_write(32'h08, 32'h110, 3'b010);
    sig_ready = 1'b0;
    ahb_write(32'h00, 32'h1, 3'b010);
    cyc = 0;
    while (!bus.SIG_VALID && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (bus.SIG_VALID !== 1'b1) $display("FAIL rmid_push: got valid=%b want 1", bus.SIG_VALID); else passes++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.SIG_VALID !== 1'b0 || bus.M_HTRANS !== 2'b00 || bus.DONE !== 1'b0)
      $display("FAIL rmid_async: got v=%b htrans=%b done=%b want 0/00/0", bus.SIG_VALID, bus.M_HTRANS, bus.DONE); else passes++;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    sig_ready = 1'b1;
    v0 = valid_seen;
    ahb_read(32'h04, rd);
    checks++; if (rd !== 32'h300) $display("FAIL rmid_bgn: got %h want 00000300", rd); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (valid_seen - v0 !== 0) $display("FAIL rmid_no_word: got %0d valid cycles want 0", valid_seen - v0); else passes++;
    ahb_write(32'h04, 32'h100, 3'b010);
    ahb_write(32'h08, 32'h108, 3'b010);
    n0 = cap_data.size();
    ahb_write(32'h00, 32'h1, 3'b010);
    wait_done(200, cyc);
    checks++; if (cap_data.size() - n0 !== 2 || cap_data[n0] !== 32'h11 || cap_data[n0+1] !== 32'h22)
      $display("FAIL rmid_restart: got %0d words want 2 = 11 22", cap_data.size() - n0); else passes++;
    ahb_read(32'h0C, rd);
    checks++; if (rd !== 32'h0002_0002) $display("FAIL rmid_status: got %h want 00020002", rd); else passes++;
  endtask

  initial begin
    bus.S_HSEL = 1'b0; bus.S_HTRANS = 2'b00; bus.S_HWRITE = 1'b0; bus.S_HSIZE = 3'b010;
    bus.S_HADDR = 32'h0; bus.S_HWDATA = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_regs();
    test_basic();
    test_stall();
    test_back_to_back_bp();
    test_error();
    test_empty();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
